// File: rtl/patseq_pkg.sv
// Shared types and constants for the pattern sequencer.
package patseq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // A frame is 4Mi cells delivered as 2048-cell rows.
  localparam int CELLS_PER_FRAME    = 4 * 1024 * 1024;
  localparam int CELLS_PER_ROW      = 2048;
  localparam int ROWS_PER_FRAME_DEF = CELLS_PER_FRAME / CELLS_PER_ROW;

endpackage

// File: rtl/patseq_frame_counter.sv
// Passive tap on the generator output: counts TLAST rows and completed frames.
module patseq_frame_counter
  import patseq_pkg::*;
#(
  parameter int ROWS_PER_FRAME = ROWS_PER_FRAME_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clear,
  input  logic        MON_TVALID,
  input  logic        MON_TREADY,
  input  logic        MON_TLAST,
  output logic [31:0] frames_done
);

  localparam int RW = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS_PER_FRAME - 1);

  logic [RW-1:0] row_cnt;
  logic          row_end;

  assign row_end = MON_TVALID & MON_TREADY & MON_TLAST;

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      row_cnt     <= '0;
      frames_done <= '0;
    end else if (row_end) begin
      if (row_cnt == ROW_LAST) begin
        row_cnt     <= '0;
        frames_done <= frames_done + 32'd1;
      end else begin
        row_cnt <= row_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Feeds table patterns to the frame generator, then waits for the frames to drain.
// Build option PATSEQ_CONTINUOUS_EN: frame_count == 0 issues patterns until stop.
module pattern_sequencer
  import patseq_pkg::*;
#(
  parameter int PATTERN_WIDTH  = 32,
  parameter int TABLE_DEPTH    = 16,
  parameter int ROWS_PER_FRAME = ROWS_PER_FRAME_DEF,
  parameter int AW             = $clog2(TABLE_DEPTH)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     cfg_wr,
  input  logic [AW-1:0]            cfg_addr,
  input  logic [PATTERN_WIDTH-1:0] cfg_data,
  input  logic [AW:0]              pattern_count,
  input  logic [31:0]              frame_count,
  input  logic                     start,
  input  logic                     stop,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              frames_done,
  output logic [PATTERN_WIDTH-1:0] AXIS_OUT_TDATA,
  output logic                     AXIS_OUT_TVALID,
  input  logic                     AXIS_OUT_TREADY,
  input  logic                     MON_TVALID,
  input  logic                     MON_TREADY,
  input  logic                     MON_TLAST
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(TABLE_DEPTH);

  logic [TABLE_DEPTH-1:0][PATTERN_WIDTH-1:0] pat_tbl;

  state_t      state;
  logic [AW-1:0] index, index_nxt;
  logic [AW:0] pcnt;
  logic [31:0] fcnt, issued;
  logic        stop_lat, tvalid;
  logic        fc_ok, start_ok, hs, last_hs;

`ifdef PATSEQ_CONTINUOUS_EN
  assign fc_ok = 1'b1;
`else
  assign fc_ok = (frame_count != 32'd0);
`endif

  assign start_ok  = (state == ST_IDLE) && start && (pattern_count != '0) &&
                     (pattern_count <= DEPTH_W) && fc_ok;
  assign hs        = tvalid & AXIS_OUT_TREADY;
  // fcnt == 0 only survives start in continuous builds: never a last handshake.
  assign last_hs   = (fcnt != 32'd0) && ((issued + 32'd1) == fcnt);
  assign index_nxt = ({1'b0, index} == (pcnt - 1'b1)) ? '0 : index + 1'b1;

  assign busy            = (state != ST_IDLE);
  assign AXIS_OUT_TVALID = tvalid;
  assign AXIS_OUT_TDATA  = pat_tbl[index];

  // Table is frozen while busy so the stream stays consistent.
  always_ff @(posedge clk) begin
    if (cfg_wr && (state == ST_IDLE) && ({1'b0, cfg_addr} < DEPTH_W))
      pat_tbl[cfg_addr] <= cfg_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      tvalid   <= 1'b0;
      done     <= 1'b0;
      index    <= '0;
      issued   <= '0;
      stop_lat <= 1'b0;
      pcnt     <= '0;
      fcnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state    <= ST_FEED;
            tvalid   <= 1'b1;
            index    <= '0;
            issued   <= '0;
            stop_lat <= 1'b0;
            pcnt     <= pattern_count;
            fcnt     <= frame_count;
          end
        end
        ST_FEED: begin
          if (hs) begin
            issued <= issued + 32'd1;
            index  <= index_nxt;
            if (last_hs || stop_lat || stop) begin
              tvalid   <= 1'b0;
              state    <= ST_DRAIN;
              stop_lat <= 1'b0;
            end
          end else if (stop) begin
            // Hold the offered beat; leave after it is accepted.
            stop_lat <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (frames_done == issued) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  patseq_frame_counter #(
    .ROWS_PER_FRAME(ROWS_PER_FRAME)
  ) u_frame_counter (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (start_ok),
    .MON_TVALID (MON_TVALID),
    .MON_TREADY (MON_TREADY),
    .MON_TLAST  (MON_TLAST),
    .frames_done(frames_done)
  );

endmodule

// File: tb/tb_pattern_sequencer.sv
// Randomized bench for pattern_sequencer against a behavioural stream/frame model.
module tb_pattern_sequencer;
  localparam int PW = 32, TD = 16, AW = 4, RPF = 2048;

  logic          clk = 1'b0, resetn = 1'b0;
  logic          cfg_wr = 1'b0, start = 1'b0, stop = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [PW-1:0] cfg_data = '0;
  logic [AW:0]   pattern_count = '0;
  logic [31:0]   frame_count = '0;
  logic          busy, done;
  logic [31:0]   frames_done;
  logic [PW-1:0] AXIS_OUT_TDATA;
  logic          AXIS_OUT_TVALID;
  logic          AXIS_OUT_TREADY = 1'b0;
  logic          MON_TVALID = 1'b0, MON_TREADY = 1'b0, MON_TLAST = 1'b0;

  always #5 clk = ~clk;

  pattern_sequencer #(.PATTERN_WIDTH(PW), .TABLE_DEPTH(TD), .ROWS_PER_FRAME(RPF)) dut (
    .clk(clk), .resetn(resetn), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .pattern_count(pattern_count), .frame_count(frame_count), .start(start), .stop(stop),
    .busy(busy), .done(done), .frames_done(frames_done),
    .AXIS_OUT_TDATA(AXIS_OUT_TDATA), .AXIS_OUT_TVALID(AXIS_OUT_TVALID),
    .AXIS_OUT_TREADY(AXIS_OUT_TREADY),
    .MON_TVALID(MON_TVALID), .MON_TREADY(MON_TREADY), .MON_TLAST(MON_TLAST)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: k-th accepted beat carries tbl_m[k % pc_m]; frames = rows / RPF.
  logic [PW-1:0] tbl_m [TD];
  int            pc_m = 1, nexp = 0, hs_cnt = 0, done_seen = 0, rows_m = 0;
  bit            pend = 1'b0, last_tv = 1'b0;
  logic [PW-1:0] pend_data = '0;

  task automatic observe();
    if (pend) begin
      chk("hold_valid", AXIS_OUT_TVALID, 1'b1);
      chk("hold_data", AXIS_OUT_TDATA, pend_data);
    end
    if (AXIS_OUT_TVALID && AXIS_OUT_TREADY) begin
      chk("tdata", AXIS_OUT_TDATA, tbl_m[nexp % pc_m]);
      nexp++;
      hs_cnt++;
    end
    pend      = AXIS_OUT_TVALID && !AXIS_OUT_TREADY;
    pend_data = AXIS_OUT_TDATA;
    if (done) done_seen++;
    last_tv = AXIS_OUT_TVALID;
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tbl(input int addr, input logic [PW-1:0] d);
    cfg_wr = 1'b1; cfg_addr = AW'(addr); cfg_data = d;
    tbl_m[addr] = d;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic start_run(input int pc, input int fc, input bit with_stop);
    pattern_count = (AW+1)'(pc); frame_count = fc; start = 1'b1; stop = with_stop;
    pc_m = (pc > 0) ? pc : 1; nexp = 0; hs_cnt = 0; done_seen = 0; rows_m = 0;
    tick();
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic feed(input int rdy_pct);
    int  n  = 0;
    bit  go = 1'b1;
    while (go) begin
      AXIS_OUT_TREADY = ($urandom_range(99) < rdy_pct);
      tick();
      n++;
      go = last_tv && (n < 5000);
    end
    AXIS_OUT_TREADY = 1'b0;
    chk("feed_bound", (n < 5000), 1'b1);
  endtask

  task automatic drive_rows(input int target, input bit fast);
    int n = 0, guard = 0;
    while (n < target && guard < 60000) begin
      MON_TVALID = 1'b1;
      MON_TREADY = fast ? 1'b1 : ($urandom_range(7) != 0);
      MON_TLAST  = fast ? 1'b1 : ($urandom_range(15) != 0);
      if (MON_TVALID && MON_TREADY && MON_TLAST) n++;
      tick();
      guard++;
    end
    MON_TVALID = 1'b0; MON_TREADY = 1'b0; MON_TLAST = 1'b0;
    rows_m += n;
    chk("rows_bound", (n == target), 1'b1);
  endtask

  task automatic finish_frames();
    int n = 0;
    drive_rows(hs_cnt * RPF - 1 - rows_m, hs_cnt > 3);
    tick(); tick();
    chk("drain_wait_busy", busy, 1'b1);
    chk("no_early_done", done_seen, 0);
    chk("frames_partial", frames_done, rows_m / RPF);
    drive_rows(1, 1'b1);
    while (done_seen == 0 && n < 10) begin tick(); n++; end
    tick(); tick();
    chk("done_pulse", done_seen, 1);
    chk("frames_final", frames_done, hs_cnt);
    chk("idle_after_done", busy, 1'b0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    pend   = 1'b0;
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_tvalid", AXIS_OUT_TVALID, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_frames", frames_done, 32'd0);
    resetn = 1'b1;
    pend   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < TD; i++) tbl_m[i] = '0;
    tick(); tick();
    do_reset();
    for (int i = 0; i < TD; i++) write_tbl(i, $urandom);

    // Fixed A,B,C table, 5 frames; a simultaneous stop must be discarded.
    write_tbl(0, 32'hAAAA_0001);
    write_tbl(1, 32'hBBBB_0002);
    write_tbl(2, 32'hCCCC_0003);
    start_run(3, 5, 1'b1);
    chk("busy_after_start", busy, 1'b1);
    feed(100);
    chk("abc_issued", hs_cnt, 5);
    finish_frames();

    // Starts that must be ignored.
    stop = 1'b1; tick(); stop = 1'b0;
    start_run(0, 3, 1'b0);
    chk("pc0_busy", busy, 1'b0);
    chk("pc0_tvalid", AXIS_OUT_TVALID, 1'b0);
    start_run(TD + 1, 3, 1'b0);
    chk("pc_big_busy", busy, 1'b0);
`ifndef PATSEQ_CONTINUOUS_EN
    start_run(2, 0, 1'b0);
    tick();
    chk("fc0_busy", busy, 1'b0);
    chk("fc0_tvalid", last_tv, 1'b0);
`endif

    // Random table, counts and backpressure; writes and starts while busy are ignored.
    for (int r = 0; r < 3; r++) begin
      int pc, fc;
      for (int i = 0; i < TD; i++) write_tbl(i, $urandom);
      pc = $urandom_range(4, 1);
      fc = $urandom_range(3, 1);
      start_run(pc, fc, 1'b0);
      cfg_wr = 1'b1; cfg_addr = '0; cfg_data = ~tbl_m[0]; start = 1'b1;
      tick();
      cfg_wr = 1'b0; start = 1'b0;
      feed(60);
      chk("rand_issued", hs_cnt, fc);
      finish_frames();
    end

    // Stall 10 cycles with a stop arriving while the beat is pending.
    start_run(2, 100, 1'b0);
    AXIS_OUT_TREADY = 1'b1; tick();
    AXIS_OUT_TREADY = 1'b0; tick();
    stop = 1'b1; tick(); stop = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("stall_no_issue", hs_cnt, 1);
    chk("stall_busy", busy, 1'b1);
    AXIS_OUT_TREADY = 1'b1; tick();
    AXIS_OUT_TREADY = 1'b0; tick();
    chk("stop_drop_valid", last_tv, 1'b0);
    chk("stop_issued", hs_cnt, 2);
    finish_frames();

    // Stop coinciding with a handshake, then reset mid-drain.
    start_run(3, 100, 1'b0);
    AXIS_OUT_TREADY = 1'b1; tick();
    stop = 1'b1; tick();
    stop = 1'b0; AXIS_OUT_TREADY = 1'b0; tick();
    chk("stop_hs_valid", last_tv, 1'b0);
    chk("stop_hs_issued", hs_cnt, 2);
    drive_rows(1000, 1'b1);
    chk("mid_drain_frames", frames_done, 32'd0);
    chk("mid_drain_busy", busy, 1'b1);
    do_reset();
    start_run(3, 1, 1'b0);
    feed(100);
    chk("post_rst_issued", hs_cnt, 1);
    finish_frames();

`ifdef PATSEQ_CONTINUOUS_EN
    write_tbl(0, 32'h1111_AAAA);
    write_tbl(1, 32'h2222_BBBB);
    start_run(2, 0, 1'b0);
    AXIS_OUT_TREADY = 1'b1;
    for (int i = 0; i < 18; i++) tick();
    chk("cont_still_busy", busy, 1'b1);
    chk("cont_issued", hs_cnt, 18);
    stop = 1'b1; tick(); stop = 1'b0;
    AXIS_OUT_TREADY = 1'b0; tick();
    chk("cont_stop_valid", last_tv, 1'b0);
    finish_frames();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
